// File: rtl/scan_bridge_pkg.sv
// Shared FSM type, chain-layout helpers and parity function for scan_bus_bridge.
package scan_bridge_pkg;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam int unsigned PAR_MAX_W = 4096;

    function automatic int unsigned off_wen();
        return 0;
    endfunction

    function automatic int unsigned off_ren();
        return 1;
    endfunction

    function automatic int unsigned off_addr();
        return 2;
    endfunction

    function automatic int unsigned off_wdata(input int unsigned aw);
        return 2 + aw;
    endfunction

    function automatic int unsigned off_rdata(input int unsigned aw, input int unsigned dw);
        return 2 + aw + dw;
    endfunction

    function automatic int unsigned off_ready(input int unsigned aw, input int unsigned dw);
        return 2 + aw + 2 * dw;
    endfunction

    function automatic int unsigned off_err(input int unsigned aw, input int unsigned dw);
        return 3 + aw + 2 * dw;
    endfunction

    function automatic int unsigned off_parity(input int unsigned aw, input int unsigned dw);
        return 4 + aw + 2 * dw;
    endfunction

    function automatic int unsigned chain_len(input int unsigned aw, input int unsigned dw,
                                              input bit par_en);
        return 4 + aw + 2 * dw + (par_en ? 1 : 0);
    endfunction

    // Zero padding leaves the result unchanged, so callers cast narrower vectors up.
    function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/scan_sync.sv
// Multi-flop synchroniser for one asynchronous scan pin, with rising- and any-edge pulses.
module scan_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic toggle
);
    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
            prev   <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign q      = stages[SYNC_STAGES-1];
    assign rise   = q & ~prev;
    assign toggle = q ^ prev;

endmodule

// File: rtl/scan_bus_bridge.sv
// Scan-chain to register/SRAM bus bridge; each scan_id toggle runs one bus read or write.
// Optional odd parity over the command fields is enabled by defining SCAN_BRIDGE_PARITY_EN.
module scan_bus_bridge #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_phi,
    input  logic              scan_phi_bar,
    input  logic              scan_data_in,
    input  logic              scan_load_chip,
    input  logic              scan_load_chain,
    input  logic              scan_id,
    output logic              scan_data_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    import scan_bridge_pkg::*;

`ifdef SCAN_BRIDGE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int unsigned OFF_WEN   = off_wen();
    localparam int unsigned OFF_REN   = off_ren();
    localparam int unsigned OFF_ADDR  = off_addr();
    localparam int unsigned OFF_WDATA = off_wdata(ADDR_W);
    localparam int unsigned CMD_W     = off_rdata(ADDR_W, DATA_W);
    localparam int unsigned N         = chain_len(ADDR_W, DATA_W, PAR_EN);
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC);

    logic [5:0] raw, lvl, rise, tog;
    logic       unused_sync;
    logic       data_in, phi_rise, bar_rise, chip_rise, load_chain, id_tog;

    assign raw = {scan_id, scan_load_chain, scan_load_chip, scan_phi_bar, scan_phi, scan_data_in};

    for (genvar i = 0; i < 6; i++) begin : g_sync
        scan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .d      (raw[i]),
            .q      (lvl[i]),
            .rise   (rise[i]),
            .toggle (tog[i])
        );
    end

    assign data_in     = lvl[0];
    assign phi_rise    = rise[1];
    assign bar_rise    = rise[2];
    assign chip_rise   = rise[3];
    assign load_chain  = lvl[4];
    assign id_tog      = tog[5];
    assign unused_sync = ^{lvl[5], lvl[3:1], rise[5:4], rise[0], tog[4:0]};

    logic [N-1:0]      chain, load_val;
    logic [CMD_W-1:0]  shadow_cmd;
    logic              master, bar_pend, bar_go, parity_ok;
    logic [DATA_W-1:0] rdata;
    logic              ready, err;

    // A phi_bar edge coinciding with a phi edge is deferred one clk so phi wins.
    assign bar_go = bar_rise | bar_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain         <= '0;
            master        <= 1'b0;
            bar_pend      <= 1'b0;
            scan_data_out <= 1'b0;
        end else begin
            scan_data_out <= chain[0];
            if (phi_rise) begin
                bar_pend <= bar_go;
                if (load_chain) chain <= load_val;
                else            master <= data_in;
            end else begin
                bar_pend <= 1'b0;
                if (bar_go && !load_chain) chain <= {master, chain[N-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow_cmd <= '0;
        else if (chip_rise) shadow_cmd <= chain[CMD_W-1:0];
    end

`ifdef SCAN_BRIDGE_PARITY_EN
    localparam int unsigned OFF_PAR = off_parity(ADDR_W, DATA_W);
    logic shadow_par, par_calc;

    assign par_calc  = odd_parity(PAR_MAX_W'(shadow_cmd));
    assign load_val  = {par_calc, err, ready, rdata, shadow_cmd};
    assign parity_ok = (shadow_par == par_calc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow_par <= 1'b0;
        else if (chip_rise) shadow_par <= chain[OFF_PAR];
    end
`else
    assign load_val  = {err, ready, rdata, shadow_cmd};
    assign parity_ok = 1'b1;
`endif

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              req_next, we_next, ready_next, err_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next, rdata_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bus_req   <= req_next;
            bus_we    <= we_next;
            bus_addr  <= addr_next;
            bus_wdata <= wdata_next;
            rdata     <= rdata_next;
            ready     <= ready_next;
            err       <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = bus_req;
        we_next    = bus_we;
        addr_next  = bus_addr;
        wdata_next = bus_wdata;
        rdata_next = rdata;
        ready_next = ready;
        err_next   = err;
        case (state)
            IDLE: begin
                if (id_tog) begin
                    if (!parity_ok || (shadow_cmd[OFF_WEN] == shadow_cmd[OFF_REN])) begin
                        err_next   = 1'b1;
                        ready_next = 1'b1;
                    end else begin
                        state_next = REQ;
                        cnt_next   = '0;
                        req_next   = 1'b1;
                        we_next    = shadow_cmd[OFF_WEN];
                        addr_next  = shadow_cmd[OFF_ADDR +: ADDR_W];
                        wdata_next = shadow_cmd[OFF_WDATA +: DATA_W];
                        ready_next = 1'b0;
                        err_next   = 1'b0;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    if (!bus_we) rdata_next = bus_rdata;
                    ready_next = 1'b1;
                    err_next   = 1'b0;
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    ready_next = 1'b1;
                    err_next   = 1'b1;
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_scan_bus_bridge.sv
// Self-checking bench for scan_bus_bridge: randomized scan/bus stimulus against a field-level model.
module tb_scan_bus_bridge;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int          TO = 16;
`ifdef SCAN_BRIDGE_PARITY_EN
    localparam int unsigned N = 4 + AW + 2 * DW + 1;
`else
    localparam int unsigned N = 4 + AW + 2 * DW;
`endif

    logic          clk, rst_n;
    logic          scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain, scan_id;
    logic          scan_data_out, bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;

    scan_bus_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .scan_phi        (scan_phi),
        .scan_phi_bar    (scan_phi_bar),
        .scan_data_in    (scan_data_in),
        .scan_load_chip  (scan_load_chip),
        .scan_load_chain (scan_load_chain),
        .scan_id         (scan_id),
        .scan_data_out   (scan_data_out),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: shadow command plus status, as a programmer sees them.
    logic          m_wen, m_ren, m_ready, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    function automatic logic [N-1:0] expected_chain();
        logic [N-1:0] v;
        v = '0;
        v[0]           = m_wen;
        v[1]           = m_ren;
        v[2 +: AW]     = m_addr;
        v[2+AW +: DW]  = m_wdata;
        v[2+AW+DW +: DW] = m_rdata;
        v[2+AW+2*DW]   = m_ready;
        v[3+AW+2*DW]   = m_err;
`ifdef SCAN_BRIDGE_PARITY_EN
        v[N-1] = ~^{m_wdata, m_addr, m_ren, m_wen};
`endif
        return v;
    endfunction

    task automatic model_clear();
        m_wen = 0; m_ren = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_ready = 0; m_err = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_phi();
        scan_phi = 1'b1; wait_cyc(3);
        scan_phi = 1'b0; wait_cyc(3);
    endtask

    task automatic rotate(input logic [N-1:0] din, output logic [N-1:0] dout);
        for (int unsigned i = 0; i < N; i++) begin
            dout[i] = scan_data_out;
            scan_data_in = din[i];
            pulse_phi();
            scan_phi_bar = 1'b1; wait_cyc(3);
            scan_phi_bar = 1'b0; wait_cyc(3);
        end
    endtask

    task automatic random_vec(output logic [N-1:0] v);
        for (int unsigned i = 0; i < N; i++) v[i] = 1'($urandom);
    endtask

    task automatic load_cmd(input logic wen, input logic ren, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic flip);
        logic [N-1:0] din, dummy;
        random_vec(din);
        din[0]          = wen;
        din[1]          = ren;
        din[2 +: AW]    = addr;
        din[2+AW +: DW] = wdata;
`ifdef SCAN_BRIDGE_PARITY_EN
        din[N-1] = (~^{wdata, addr, ren, wen}) ^ flip;
`else
        if (flip) din[0] = wen;
`endif
        rotate(din, dummy);
        scan_load_chip = 1'b1; wait_cyc(3);
        scan_load_chip = 1'b0; wait_cyc(3);
        m_wen = wen; m_ren = ren; m_addr = addr; m_wdata = wdata;
    endtask

    task automatic readout(input string name);
        logic [N-1:0] din, dout, exp;
        scan_load_chain = 1'b1; wait_cyc(3);
        pulse_phi();
        scan_load_chain = 1'b0; wait_cyc(3);
        random_vec(din);
        rotate(din, dout);
        exp = expected_chain();
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL readout_%s: got %h expected %h", name, dout, exp);
        end
    endtask

    task automatic launch(input logic expect_req);
        @(negedge clk);
        scan_id = ~scan_id;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL launch_early: bus_req got %b expected 0", bus_req);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_req !== expect_req) begin
            errors++;
            $display("FAIL launch_latency: bus_req got %b expected %b", bus_req, expect_req);
        end
    endtask

    task automatic expect_idle_bus(input string name);
        int seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus_req !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s_no_req: bus_req high cycles got %0d expected 0", name, seen);
        end
    endtask

    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rd, input int delay, input string name);
        load_cmd(we, ~we, addr, wdata, 1'b0);
        launch(1'b1);
        checks++;
        if ({bus_we, bus_addr, bus_wdata} !== {we, addr, wdata}) begin
            errors++;
            $display("FAIL %s_bus: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                     name, bus_we, bus_addr, bus_wdata, we, addr, wdata);
        end
        repeat (delay - 1) @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = rd;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_req_drop: bus_req got %b expected 0", name, bus_req);
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
        if (!we) m_rdata = rd;
        m_ready = 1'b1; m_err = 1'b0;
        readout(name);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, scan_data_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h sdo=%b expected all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, scan_data_out);
        end
        model_clear();
        readout("reset");
    endtask

    task automatic test_write();
        do_txn(1'b1, 20'h00480, 32'h0000_0001, 32'hFFFF_FFFF, 2, "write");
    endtask

    task automatic test_read();
        do_txn(1'b0, 20'h00600, 32'h1234_5678, 32'h0000_0007, 3, "read");
    endtask

    task automatic test_timeout();
        int high = 1;
        load_cmd(1'b0, 1'b1, 20'h0ABCD, $urandom, 1'b0);
        launch(1'b1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 3) scan_id = ~scan_id;
            if (bus_req === 1'b1) high++;
            else break;
        end
        checks++;
        if (high != TO) begin
            errors++;
            $display("FAIL timeout_len: bus_req high cycles got %0d expected %0d", high, TO);
        end
        m_err = 1'b1; m_ready = 1'b1;
        readout("timeout");
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            do_txn(1'b1, 20'($urandom), $urandom, $urandom, 1, "pre_illegal");
            load_cmd(k == 0, k == 0, 20'($urandom), $urandom, 1'b0);
            launch(1'b0);
            expect_idle_bus("illegal");
            m_err = 1'b1; m_ready = 1'b1;
            readout("illegal");
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int unsigned kind = $urandom_range(0, 2);
            if (kind == 2) begin
                logic v = 1'($urandom);
                load_cmd(v, v, 20'($urandom), $urandom, 1'b0);
                launch(1'b0);
                m_err = 1'b1; m_ready = 1'b1;
                readout("rand_illegal");
            end else begin
                do_txn(kind == 1, 20'($urandom), $urandom, $urandom, $urandom_range(1, 8), "rand_txn");
            end
        end
    endtask

`ifdef SCAN_BRIDGE_PARITY_EN
    task automatic test_parity();
        load_cmd(1'b1, 1'b0, 20'h00777, 32'hCAFE_F00D, 1'b1);
        launch(1'b0);
        expect_idle_bus("parity");
        m_err = 1'b1; m_ready = 1'b1;
        readout("parity_bad");
        do_txn(1'b1, 20'h00777, 32'hCAFE_F00D, 32'h0, 2, "parity_retry");
    endtask
`endif

    task automatic test_reset_mid_req();
        load_cmd(1'b1, 1'b0, 20'hABCDE, 32'hDEAD_BEEF, 1'b0);
        launch(1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        scan_id = 1'b0;
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_req: got req=%b we=%b addr=%h wdata=%h expected all 0",
                     bus_req, bus_we, bus_addr, bus_wdata);
        end
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        model_clear();
        readout("after_reset");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain, scan_id} = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_random();
        test_illegal();
`ifdef SCAN_BRIDGE_PARITY_EN
        test_parity();
`endif
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
